mult_eval_sweeper: RTL and testbench

//  Sequential exhaustive evaluator sitting around a candidate combinational multiplier (A,B -> P).

---
 rtl/mult_eval_sweeper_pkg.sv | 21 ++
 rtl/mult_eval_sweeper_accum.sv | 56 +++++
 rtl/mult_eval_sweeper.sv | 105 ++++++++++
 tb/tb_mult_eval_sweeper.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_eval_sweeper_pkg.sv
// Shared definitions for the multiplier sweeper: FSM encodings and width helpers.
// Widths are derived from the operand width W so every accumulator is overflow-free.
package mult_eval_sweeper_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int err_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sum_w(input int w);
        return 4 * w + 1;
    endfunction

    function automatic int npairs(input int w);
        return 1 << (2 * w);
    endfunction

endpackage

// File: rtl/mult_eval_sweeper_accum.sv
// Golden product, absolute error and the three error metrics for one operand pair per clock.
// i_clear has priority over i_en; metrics hold when neither is asserted.
module mult_eval_sweeper_accum
    import mult_eval_sweeper_pkg::*;
#(
    parameter int W  = 2,
    parameter int PW = 2 * W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_en,
    input  logic [W-1:0]          i_a,
    input  logic [W-1:0]          i_b,
    input  logic [PW-1:0]         i_p,
    output logic [err_w(W)-1:0]   o_err_count,
    output logic [PW-1:0]         o_max_err,
    output logic [sum_w(W)-1:0]   o_sum_abs_err
);

    localparam int ERRW = err_w(W);
    localparam int SUMW = sum_w(W);

    logic [PW-1:0]   w_golden;
    logic [PW-1:0]   w_diff;
    logic [ERRW-1:0] r_err_count;
    logic [PW-1:0]   r_max_err;
    logic [SUMW-1:0] r_sum_abs_err;

    assign w_golden = PW'(i_a) * PW'(i_b);
    // Unsigned magnitude of the error, never wraps.
    assign w_diff   = (i_p >= w_golden) ? (i_p - w_golden) : (w_golden - i_p);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count   <= '0;
            r_max_err     <= '0;
            r_sum_abs_err <= '0;
        end else if (i_clear) begin
            r_err_count   <= '0;
            r_max_err     <= '0;
            r_sum_abs_err <= '0;
        end else if (i_en) begin
            r_err_count   <= r_err_count + ERRW'(w_diff != '0);
            r_sum_abs_err <= r_sum_abs_err + SUMW'(w_diff);
            if (w_diff > r_max_err) begin
                r_max_err <= w_diff;
            end
        end
    end

    assign o_err_count   = r_err_count;
    assign o_max_err     = r_max_err;
    assign o_sum_abs_err = r_sum_abs_err;

endmodule

// File: rtl/mult_eval_sweeper.sv
// Exhaustive evaluator for a combinational candidate multiplier: presents every (A,B) pair,
// one per clock, and accumulates error metrics against the exact product.
module mult_eval_sweeper
    import mult_eval_sweeper_pkg::*;
#(
    parameter int W  = 2,
    parameter int PW = 2 * W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic [PW-1:0]    cand_p,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     err_count,
    output logic [PW-1:0]    max_err,
    output logic [4*W:0]     sum_abs_err,
    output logic             pass,
    output logic [1:0]       dbg_state
);

    logic [1:0]     r_state;
    logic [2*W-1:0] r_idx;
    logic           r_done;
    logic           w_start_ok;
    logic           w_abort_run;
    logic           w_last;
    logic           w_clear;
    logic           w_en;

    // start is honoured only outside RUN; abort only inside RUN, so neither can mask the other.
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_abort_run = abort && (r_state == ST_RUN);
    assign w_last      = (r_idx == {(2 * W){1'b1}});
    assign w_clear     = w_start_ok || w_abort_run;
    assign w_en        = (r_state == ST_RUN) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= ST_RUN;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                    end else if (w_last) begin
                        r_state <= ST_DONE;
                        r_idx   <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_start_ok) begin
                        r_state <= ST_RUN;
                        r_idx   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    mult_eval_sweeper_accum #(
        .W  (W),
        .PW (PW)
    ) u_accum (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_clear),
        .i_en          (w_en),
        .i_a           (op_a),
        .i_b           (op_b),
        .i_p           (cand_p),
        .o_err_count   (err_count),
        .o_max_err     (max_err),
        .o_sum_abs_err (sum_abs_err)
    );

    assign op_a      = r_idx[W-1:0];
    assign op_b      = r_idx[2*W-1:W];
    assign busy      = (r_state == ST_RUN);
    assign done      = r_done;
    // Metrics are frozen in DONE, so pass can be derived from them directly.
    assign pass      = (r_state == ST_DONE) && (err_count == '0);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mult_eval_sweeper.sv
// Bench for mult_eval_sweeper (W=2) with a behavioural candidate multiplier and a
// scoreboard of expected operand pairs and final metrics.
module tb_mult_eval_sweeper;
    import mult_eval_sweeper_pkg::*;

    localparam int W  = 2;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [PW-1:0] cand_p;
    logic          busy;
    logic          done;
    logic [2*W:0]  err_count;
    logic [PW-1:0] max_err;
    logic [4*W:0]  sum_abs_err;
    logic          pass;
    logic [1:0]    dbg_state;

    int cand_mode;
    int n_vec = 0;
    int n_err = 0;

    logic [2*W-1:0] exp_op_q[$];
    logic [31:0]    exp_met_q[$];

    logic [PW-1:0] w_prod;

    mult_eval_sweeper #(.W(W), .PW(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .op_a        (op_a),
        .op_b        (op_b),
        .cand_p      (cand_p),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count),
        .max_err     (max_err),
        .sum_abs_err (sum_abs_err),
        .pass        (pass),
        .dbg_state   (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // candidate multiplier: 0 exact, 1 stuck-at-0, 2 (A*B+1) mod 16
    always_comb begin
        w_prod = PW'(op_a) * PW'(op_b);
        case (cand_mode)
            0:       cand_p = w_prod;
            1:       cand_p = '0;
            default: cand_p = w_prod + 4'd1;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_op_a"}, 32'(op_a), 0);
        chk({tag, "_op_b"}, 32'(op_b), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"},  32'(err_count), 0);
        chk({tag, "_max"},  32'(max_err), 0);
        chk({tag, "_sum"},  32'(sum_abs_err), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
    endtask

    // Reference model: walks all pairs, queues the operand order and the final metrics.
    task automatic push_expected(input int mode);
        int e = 0;
        int m = 0;
        int s = 0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] iv;
            logic [1:0] a;
            logic [1:0] b;
            int g;
            int c;
            int d;
            iv = 4'(i);
            a  = iv[1:0];
            b  = iv[3:2];
            g  = int'(a) * int'(b);
            case (mode)
                0:       c = g;
                1:       c = 0;
                default: c = (g + 1) % 16;
            endcase
            d = (c >= g) ? (c - g) : (g - c);
            exp_op_q.push_back(iv);
            if (d != 0) e++;
            s += d;
            if (d > m) m = d;
        end
        exp_met_q.push_back(32'(e));
        exp_met_q.push_back(32'(m));
        exp_met_q.push_back(32'(s));
        exp_met_q.push_back((e == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic run_sweep(input int mode, input int mid_start, input bit with_abort);
        int cyc;
        bit got_done;
        logic [31:0] e_err, e_max, e_sum, e_pass;
        cand_mode = mode;
        push_expected(mode);
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        cyc = 1;
        got_done = 1'b0;
        e_err = 0;
        while (cyc <= 40 && !got_done) begin
            if (cyc == 1) begin
                chk("run_busy", 32'(busy), 1);
                chk("run_state", 32'(dbg_state), 32'(ST_RUN));
            end
            if (busy) begin
                if (exp_op_q.size() == 0) chk("op_extra", 32'(busy), 0);
                else chk("op_pair", 32'({op_b, op_a}), 32'(exp_op_q.pop_front()));
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_lat", 32'(cyc), 17);
                chk("done_busy", 32'(busy), 0);
                if (exp_met_q.size() < 4) begin
                    chk("met_missing", 32'(exp_met_q.size()), 4);
                end else begin
                    e_err  = exp_met_q.pop_front();
                    e_max  = exp_met_q.pop_front();
                    e_sum  = exp_met_q.pop_front();
                    e_pass = exp_met_q.pop_front();
                    chk("err_count", 32'(err_count), e_err);
                    chk("max_err", 32'(max_err), e_max);
                    chk("sum_abs_err", 32'(sum_abs_err), e_sum);
                    chk("pass", 32'(pass), e_pass);
                end
            end
            start = (cyc == mid_start);
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!got_done) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_pulse_end", 32'(done), 0);
        chk("done_state", 32'(dbg_state), 32'(ST_DONE));
        chk("done_op_zero", 32'({op_b, op_a}), 0);
        chk("err_hold", 32'(err_count), e_err);
        exp_op_q.delete();
        exp_met_q.delete();
    endtask

    initial begin
        int dcount;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cand_mode = 0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // exact, stuck-at-0, then +1 restarted from DONE with abort (start wins) and a mid-sweep start
        run_sweep(0, 0, 1'b0);
        run_sweep(1, 0, 1'b0);
        run_sweep(2, 6, 1'b1);

        // abort on the 5th RUN edge
        cand_mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_err", 32'(err_count), 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("abort_err", 32'(err_count), 0);
        chk("abort_max", 32'(max_err), 0);
        chk("abort_sum", 32'(sum_abs_err), 0);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 0);
        run_sweep(0, 0, 1'b0);

        // asynchronous reset between edges mid-sweep
        cand_mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_reset_err", 32'(err_count), 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("post_rst_busy", 32'(busy), 0);
        run_sweep(1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
